// File: rtl/ep_arb_rr.sv
// rtl/ep_arb_rr.sv - N-way TRN endpoint-ownership arbiter with watchdog and protocol-error detection
module ep_arb_rr #(
  parameter int NCH  = 4,
  parameter int IDW  = 2,
  parameter int MODE = 0,
  parameter int TOUT = 255
) (
  input  logic           pcie_clk,
  input  logic           pcie_rst,
  input  logic [NCH-1:0] req_ep,
  input  logic [NCH-1:0] drv_ep,
  output logic [NCH-1:0] my_trn,
  output logic [IDW-1:0] grant_id,
  input  logic           chn_trn,
  output logic           chn_reqep,
  output logic           chn_drvn,
  output logic           tout_pulse,
  output logic           err_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_OWN   = 2'd2
  } state_t;

  localparam logic [15:0] TOUT_LAST = 16'(TOUT - 1);
  localparam logic [15:0] WDOG_MAX  = 16'hFFFF;

  state_t         state_q, state_d;
  logic [NCH-1:0] my_trn_q, my_trn_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    wdog_q, wdog_d;
  logic           tout_q, tout_d;
  logic           err_q, err_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand_idx;
  logic           own_drv;

  // Owner's drive bit: the only thing that moves GRANT to OWN or ends OWN.
  assign own_drv = drv_ep[grant_id_q];

  // Winner search: rotating from ptr+1 in round-robin, lowest index in fixed priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    if (MODE == 1) begin
      for (int k = 0; k < NCH; k++) begin
        cand_idx = IDW'(k);
        if (!win_found && req_ep[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        cand_idx = IDW'((int'(ptr_q) + k) % NCH);
        if (!win_found && req_ep[cand_idx]) begin
          win_found = 1'b1;
          win_idx   = cand_idx;
        end
      end
    end
  end

  // Next-state logic: grant, watchdog/parent revocation, and release on drive drop.
  always_comb begin
    state_d    = state_q;
    my_trn_d   = my_trn_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    wdog_d     = wdog_q;
    tout_d     = 1'b0;
    // Any drive from a requester not holding the token is a protocol error.
    err_d      = |(drv_ep & ~my_trn_q);
    case (state_q)
      ST_IDLE: begin
        if (chn_trn && win_found) begin
          state_d    = ST_GRANT;
          my_trn_d   = {{(NCH-1){1'b0}}, 1'b1} << win_idx;
          grant_id_d = win_idx;
          ptr_d      = win_idx;
          wdog_d     = '0;
        end
      end
      ST_GRANT: begin
        if (own_drv) begin
          state_d = ST_OWN;
        end else if (!chn_trn) begin
          // Parent withdrew before the owner started; no TLP is at risk.
          state_d  = ST_IDLE;
          my_trn_d = '0;
        end else if (wdog_q == TOUT_LAST) begin
          state_d  = ST_IDLE;
          my_trn_d = '0;
          tout_d   = 1'b1;
        end else if (wdog_q != WDOG_MAX) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      ST_OWN: begin
        // A TLP in flight is never preempted, even if the parent drops chn_trn.
        if (!own_drv) begin
          state_d  = ST_IDLE;
          my_trn_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        my_trn_d = '0;
      end
    endcase
  end

  // State and output registers; async reset drops the token immediately.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state_q    <= ST_IDLE;
      my_trn_q   <= '0;
      grant_id_q <= '0;
      ptr_q      <= IDW'(NCH - 1);
      wdog_q     <= '0;
      tout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      my_trn_q   <= my_trn_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      wdog_q     <= wdog_d;
      tout_q     <= tout_d;
      err_q      <= err_d;
    end
  end

  assign my_trn     = my_trn_q;
  assign grant_id   = grant_id_q;
  assign tout_pulse = tout_q;
  assign err_pulse  = err_q;
  assign chn_reqep  = |req_ep;
  assign chn_drvn   = (state_q != ST_IDLE) | (|drv_ep);

endmodule

// File: tb/tb_ep_arb_rr.sv
// tb/tb_ep_arb_rr.sv - randomized and directed bench for ep_arb_rr against a behavioural ownership model
module tb_ep_arb_rr;
  localparam int TOUT_T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] req[2];
  logic [3:0] drv_auto[2];
  logic [3:0] drv_extra[2];
  logic [3:0] drv[2];
  logic       chn[2];
  logic [3:0] mt[2];
  logic [1:0] gid[2];
  logic       tp[2], ep[2], creq[2], cdrv[2];
  int         drive_len[2];
  int         drv_left[2];

  assign drv[0] = drv_auto[0] | drv_extra[0];
  assign drv[1] = drv_auto[1] | drv_extra[1];

  ep_arb_rr #(.NCH(4), .IDW(2), .MODE(0), .TOUT(TOUT_T)) u0 (
    .pcie_clk(clk), .pcie_rst(rst), .req_ep(req[0]), .drv_ep(drv[0]),
    .my_trn(mt[0]), .grant_id(gid[0]), .chn_trn(chn[0]), .chn_reqep(creq[0]),
    .chn_drvn(cdrv[0]), .tout_pulse(tp[0]), .err_pulse(ep[0])
  );

  ep_arb_rr #(.NCH(4), .IDW(2), .MODE(1), .TOUT(TOUT_T)) u1 (
    .pcie_clk(clk), .pcie_rst(rst), .req_ep(req[1]), .drv_ep(drv[1]),
    .my_trn(mt[1]), .grant_id(gid[1]), .chn_trn(chn[1]), .chn_reqep(creq[1]),
    .chn_drvn(cdrv[1]), .tout_pulse(tp[1]), .err_pulse(ep[1])
  );

  // Behavioural model: who owns the endpoint, whether they started driving,
  // how long they have sat on the grant idle, and the last winner.
  int         own[2];
  int         last_w[2];
  int         age[2];
  logic [1:0] m_gid[2];
  bit         seen[2];
  bit         e_tout[2];
  bit         e_err[2];

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] tok(input int i);
    return (own[i] < 0) ? 4'b0 : 4'(1 << own[i]);
  endfunction

  function automatic int pick(input bit fixed, input int last, input logic [3:0] r);
    logic [3:0] rr;
    rr = r;
    if (fixed) begin
      for (int k = 0; k < 4; k++) if (rr[k]) return k;
    end else begin
      for (int k = 1; k <= 4; k++) if (rr[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset(input int i);
    own[i] = -1; last_w[i] = 3; age[i] = 0; m_gid[i] = 2'd0;
    seen[i] = 0; e_tout[i] = 0; e_err[i] = 0;
  endtask

  task automatic m_step(input int i);
    logic [3:0] t;
    logic [3:0] d;
    int w;
    t = tok(i);
    d = drv[i];
    e_err[i] = ((d & ~t) != 4'b0);
    e_tout[i] = 0;
    if (own[i] < 0) begin
      w = pick(i == 1, last_w[i], req[i]);
      if (chn[i] && w >= 0) begin
        own[i] = w; m_gid[i] = 2'(w); last_w[i] = w; seen[i] = 0; age[i] = 0;
      end
    end else if (seen[i]) begin
      if ((d & t) == 4'b0) own[i] = -1;
    end else if ((d & t) != 4'b0) begin
      seen[i] = 1;
    end else if (!chn[i]) begin
      own[i] = -1;
    end else begin
      age[i]++;
      if (age[i] == TOUT_T) begin
        own[i] = -1; e_tout[i] = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0); m_step(1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("my_trn", i, 32'(mt[i]), 32'(tok(i)));
        check("grant_id", i, 32'(gid[i]), 32'(m_gid[i]));
        check("tout_pulse", i, 32'(tp[i]), 32'(e_tout[i]));
        check("err_pulse", i, 32'(ep[i]), 32'(e_err[i]));
        check("chn_reqep", i, 32'(creq[i]), 32'(req[i] != 4'b0));
        check("chn_drvn", i, 32'(cdrv[i]), 32'((own[i] >= 0) || (drv[i] != 4'b0)));
      end
    end
  end

  // Requester agents: a granted requester drives for drive_len cycles (0 = never drives).
  task automatic agents();
    logic [3:0] t;
    for (int i = 0; i < 2; i++) begin
      t = tok(i);
      if (drv_left[i] > 0) begin
        drv_left[i]--;
        if (drv_left[i] == 0) drv_auto[i] = 4'b0;
      end else if (t != 4'b0 && !seen[i] && drv_auto[i] == 4'b0 && drive_len[i] > 0) begin
        drv_auto[i] = t;
        drv_left[i] = drive_len[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    agents();
  endtask

  task automatic clear_agents();
    for (int i = 0; i < 2; i++) begin
      drv_auto[i] = 4'b0; drv_extra[i] = 4'b0; drv_left[i] = 0;
    end
  endtask

  task automatic wait_grant(input int i, input string nm);
    int c;
    c = 0;
    while (mt[i] == 4'b0 && c < 20) begin
      step();
      c++;
    end
    if (mt[i] == 4'b0) check(nm, i, 32'(mt[i]), 32'hF);
  endtask

  logic [3:0] g[$];
  logic [3:0] rr_exp[5];
  logic [3:0] prev;
  int gap, hi, cnt, cnt1, other;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 4'b0; chn[i] = 1'b0; drive_len[i] = 0;
      m_reset(i);
    end
    clear_agents();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    @(posedge clk); #1 chk_en = 1;
    check("rst_my_trn", 0, 32'(mt[0]), 32'h0);
    check("rst_grant_id", 0, 32'(gid[0]), 32'h0);
    @(posedge clk); #1 rst = 0;

    // Round-robin: all four requesting, each owner drives 3 cycles.
    req[0] = 4'b1111; chn[0] = 1; drive_len[0] = 3;
    prev = 4'b0; gap = 0;
    for (int c = 0; c < 40 && g.size() < 5; c++) begin
      step();
      if (mt[0] != 4'b0) begin
        if (prev == 4'b0) begin
          g.push_back(mt[0]);
          if (g.size() > 1) check("rr_gap", 0, 32'(gap), 32'd1);
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev = mt[0];
    end
    check("rr_count", 0, 32'(g.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check("rr_order", k, 32'((k < g.size()) ? g[k] : 4'b0), 32'(rr_exp[k]));
    req[0] = 4'b0;
    repeat (6) step();

    // Asynchronous reset while channel 2 owns.
    req[0] = 4'b0100; drive_len[0] = 10;
    wait_grant(0, "rst_grant_timeout");
    step(); step();
    check("pre_rst_own", 0, 32'(mt[0]), 32'h4);
    @(posedge clk);
    #3 rst = 1;
    clear_agents();
    #1;
    check("rst_async_my_trn", 0, 32'(mt[0]), 32'h0);
    check("rst_async_grant_id", 0, 32'(gid[0]), 32'h0);
    req[0] = 4'b0001; chn[0] = 1; drive_len[0] = 3;
    @(posedge clk); #1 rst = 0;
    step();
    check("post_rst_grant", 0, 32'(mt[0]), 32'h1);
    req[0] = 4'b0;
    repeat (6) step();

    // Watchdog: channel 2 never drives.
    drive_len[0] = 0; req[0] = 4'b0100;
    wait_grant(0, "wd_grant_timeout");
    check("wd_grant", 0, 32'(mt[0]), 32'h4);
    req[0] = 4'b1100;
    hi = 1;
    for (int c = 0; c < 40 && mt[0][2]; c++) begin
      step();
      if (mt[0][2]) hi++;
    end
    check("wd_len", 0, 32'(hi), 32'd8);
    check("wd_tout", 0, 32'(tp[0]), 32'h1);
    drive_len[0] = 3;
    step();
    check("wd_tout_once", 0, 32'(tp[0]), 32'h0);
    check("wd_next", 0, 32'(mt[0]), 32'h8);
    req[0] = 4'b0;
    repeat (8) step();

    // Parent handshake.
    chn[0] = 0; req[0] = 4'b0100; drive_len[0] = 6;
    repeat (3) begin
      step();
      check("hs_reqep", 0, 32'(creq[0]), 32'h1);
      check("hs_no_grant", 0, 32'(mt[0]), 32'h0);
    end
    chn[0] = 1;
    wait_grant(0, "hs_grant_timeout");
    chn[0] = 0;
    cnt = 0;
    for (int c = 0; c < 20 && mt[0] != 4'b0; c++) begin
      check("hs_drvn", 0, 32'(cdrv[0]), 32'h1);
      cnt++;
      step();
    end
    check("hs_own_len", 0, 32'(cnt), 32'd7);
    req[0] = 4'b0; chn[0] = 1;
    repeat (4) step();

    // Protocol error: channel 1 drives while channel 0 owns.
    req[0] = 4'b0001; drive_len[0] = 5;
    wait_grant(0, "err_grant_timeout");
    step();
    drv_extra[0] = 4'b0010;
    step();
    drv_extra[0] = 4'b0;
    check("err_pulse_hit", 0, 32'(ep[0]), 32'h1);
    check("err_owner_kept", 0, 32'(mt[0]), 32'h1);
    step();
    check("err_pulse_once", 0, 32'(ep[0]), 32'h0);
    check("err_owner_still", 0, 32'(mt[0]), 32'h1);
    req[0] = 4'b0;
    repeat (8) step();

    // Fixed priority on the second instance.
    req[1] = 4'b1010; chn[1] = 1; drive_len[1] = 2;
    prev = 4'b0; cnt1 = 0; other = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (mt[1] != 4'b0 && prev == 4'b0) begin
        if (mt[1] == 4'b0010) cnt1++; else other++;
      end
      prev = mt[1];
    end
    check("fp_ch1_wins", 1, 32'(cnt1 >= 3), 32'h1);
    check("fp_no_other", 1, 32'(other), 32'h0);
    req[1] = 4'b1000;
    cnt = 0;
    for (int c = 0; c < 20 && cnt == 0; c++) begin
      step();
      if (mt[1] != 4'b0 && prev == 4'b0) begin
        cnt = 1;
        check("fp_ch3_after_drop", 1, 32'(mt[1]), 32'h8);
      end
      prev = mt[1];
    end
    if (cnt == 0) check("fp_ch3_timeout", 1, 32'h0, 32'h1);
    req[1] = 4'b0;
    repeat (6) step();

    // Randomized traffic on both instances, with one mid-run async reset.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        @(posedge clk);
        #3 rst = 1;
        clear_agents();
        @(posedge clk);
        #1 rst = 0;
      end
      step();
      for (int i = 0; i < 2; i++) begin
        if ($urandom % 4 == 0) req[i] = 4'($urandom);
        chn[i] = ($urandom % 6) != 0;
        if (drv_left[i] == 0 && $urandom % 3 == 0) drive_len[i] = $urandom_range(0, 4);
        drv_extra[i] = ($urandom % 20 == 0) ? 4'($urandom) : 4'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ep_arb_rr.md
# ep_arb_rr

Parametrised N-way endpoint-ownership arbiter for the PCIe TRN transmit path. It generalises the fixed tx/rx/irq arbiter of a channel to NCH requesters with round-robin or fixed-priority selection. It adds a grant watchdog and protocol-error detection, and chains upward to a parent arbiter through the chn_trn/chn_drvn/chn_reqep handshake. It sits inside a channel between its sub-blocks (each with my_trn/drv_ep/req_ep) and the top-level EP arbiter.

## Interface
- NCH, 4: number of requesters, 2..16.
- IDW, 2: width of grant_id; must equal ceil(log2(NCH)).
- MODE, 0: 0 = round-robin, 1 = fixed priority (index 0 highest).
- TOUT, 255: max cycles in GRANT without drv_ep before revocation; 1..2^16-1.
- pcie_clk  in  1  clock; all logic on rising edge.
- pcie_rst  in  1  reset; asynchronous, active-high.
- req_ep  in  NCH  requester i wants the endpoint.
- drv_ep  in  NCH  requester i is driving the TRN tx bus.
- my_trn  out  NCH  one-hot token; requester i may drive.
- grant_id  out  IDW  index of current/last owner.
- chn_trn  in  1  parent grants this arbiter the endpoint.
- chn_reqep  out  1  this arbiter wants the endpoint.
- chn_drvn  out  1  this arbiter holds or is using the endpoint.
- tout_pulse  out  1  one-cycle pulse on watchdog revocation.
- err_pulse  out  1  one-cycle pulse on drv_ep from a non-owner.

## Operation
- States: IDLE, GRANT, OWN. Reset: IDLE, my_trn=0, grant_id=0, tout_pulse=0, err_pulse=0, RR pointer=NCH-1, watchdog=0.
- chn_reqep = |req_ep (combinational). chn_drvn = (state != IDLE) | (|drv_ep) (combinational).
- IDLE: if chn_trn=1 and |req_ep, select winner w, set my_trn=1<<w, grant_id=w, clear watchdog, go GRANT. Otherwise stay.
- Selection: MODE 0 picks the first set req_ep at index ptr+1, ptr+2, ... modulo NCH. MODE 1 picks the lowest set index. On each grant, ptr <= w.
- GRANT: if drv_ep[w]=1, go OWN. Else if watchdog == TOUT-1, clear my_trn, pulse tout_pulse, go IDLE; ptr is already w, so the next search starts at w+1. Else increment watchdog.
- GRANT with chn_trn=0 and drv_ep[w]=0: revoke immediately. my_trn=0, go IDLE, no tout_pulse.
- OWN: hold my_trn while drv_ep[w]=1, regardless of chn_trn; a TLP in flight is never preempted. When drv_ep[w]=0, clear my_trn and go IDLE.
- req_ep[w] dropping in GRANT or OWN has no effect; only drv_ep ends ownership.
- err_pulse fires for any cycle with drv_ep[i]=1 where i ≠ current owner, or with no owner (IDLE). It is registered, so it appears one cycle later. The offending drv_ep is otherwise ignored.
- Watchdog width is 16 bits and saturates; it never wraps.

## Timing
- Grant latency: req_ep and chn_trn sampled high in IDLE at edge t gives my_trn high after edge t (visible in cycle t+1).
- Release: drv_ep[w] sampled low in OWN at edge t gives my_trn low in cycle t+1. The next grant is visible in cycle t+2 at the earliest, so there is one dead cycle between owners and never two my_trn bits set.
- Back-to-back: a requester holding req_ep continuously in MODE 0 with other requesters active waits at most NCH-1 ownership periods.
- Timeout: my_trn high for exactly TOUT cycles, then low. tout_pulse is high in the first cycle my_trn is low.
- Asynchronous reset mid-OWN: my_trn drops immediately. The sub-block must abort its TLP; this is a system-level requirement.

## Test plan
- Reset: assert pcie_rst mid-OWN -> my_trn=0 and grant_id=0 immediately; after release, req_ep=4'b0001 and chn_trn=1 -> my_trn=4'b0001 one cycle later.
- Round-robin: MODE=0, req_ep=4'b1111 held; each owner holds drv_ep 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between owners.
- Fixed priority: MODE=1, req_ep=4'b1010 held -> channel 1 wins every time; channel 3 is granted only after req_ep[1] is dropped.
- Watchdog: TOUT=8, grant to channel 2 with drv_ep never asserted -> my_trn[2] high 8 cycles, tout_pulse once, next grant goes to channel 3 if it is requesting.
- Parent handshake: chn_trn=0 with req_ep=4'b0100 -> chn_reqep=1 and my_trn=0; chn_trn drops during OWN -> ownership kept until drv_ep falls; chn_drvn stays high throughout.
- Protocol error: owner 0, drv_ep=4'b0011 for 1 cycle -> one err_pulse next cycle; owner 0 unaffected.
